// File: rtl/rr_decoder_scheduler.sv
// Round-robin owner of a shared 3x8 decoder bus: registered sel/en/gnt with one dead cycle between owners.
// Optional hold budget (MAX_HOLD cycles, timeout pulse) enabled by defining RRS_TIMEOUT_EN.
module rr_decoder_scheduler #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] req_i,
  output logic [2:0] sel_o,
  output logic       en_o,
  output logic [7:0] gnt_o,
  output logic       busy_o,
  output logic       timeout_o
);

  if ((1 << HOLD_W) <= MAX_HOLD || MAX_HOLD < 1 || MAX_HOLD > 31) begin : g_bad_hold
    $error("MAX_HOLD must be 1..31 and fit in HOLD_W bits");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic       en_q, en_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  logic       found;
  logic [2:0] idx;
  logic [2:0] cand;

  // First asserted request scanning ptr, ptr+1, ... modulo 8.
  always_comb begin
    found = 1'b0;
    idx   = ptr_q;
    cand  = ptr_q;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

`ifdef RRS_TIMEOUT_EN
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              budget_spent;

  assign budget_spent = (cnt_q == HOLD_W'(MAX_HOLD - 1));
`else
  logic budget_spent;

  assign budget_spent = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
`ifdef RRS_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle, StGap: begin
        if (found) begin
          state_d = StGrant;
          sel_d   = idx;
          en_d    = 1'b1;
          gnt_d   = 8'b1 << idx;
          busy_d  = 1'b1;
`ifdef RRS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = StIdle;
          en_d    = 1'b0;
          gnt_d   = 8'b0;
          busy_d  = 1'b0;
        end
      end
      StGrant: begin
        // Release takes precedence over the budget, so no pulse when both coincide.
        if (!req_i[sel_q] || budget_spent) begin
          state_d = StGap;
          en_d    = 1'b0;
          gnt_d   = 8'b0;
          busy_d  = 1'b0;
          ptr_d   = sel_q + 3'd1;
`ifdef RRS_TIMEOUT_EN
          timeout_d = req_i[sel_q];
`endif
        end else begin
`ifdef RRS_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        en_d    = 1'b0;
        gnt_d   = 8'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      ptr_q   <= 3'b000;
      sel_q   <= 3'b000;
      en_q    <= 1'b0;
      gnt_q   <= 8'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef RRS_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign sel_o  = sel_q;
  assign en_o   = en_q;
  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;

endmodule
